// File: rtl/seq_pkg.sv
// Shared definitions for the "0110" serial link: FSM encodings and line constants
// used by both the transmitter and the receiving detector.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [3:0] PATTERN_0110 = 4'b0110;
  localparam logic       IDLE_BIT_DEF = 1'b1;
  localparam int         GAP_CNT_W    = 4;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in/serial-out shifter: load presents the pattern MSB on ser the next cycle,
// each shift presents the next bit; last flags that ser holds the LSB.
module seq_piso #(
  parameter int             PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
  parameter logic           IDLE_BIT = 1'b1
) (
  input  logic ck,
  input  logic rs,
  input  logic load,
  input  logic shift,
  input  logic clear,
  output logic ser,
  output logic last
);

  localparam int IW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

  logic [PAT_W-1:0] sr;
  logic [IW-1:0]    idx;

  // sr holds the bits still to come, already aligned so the next one is at the MSB.
  always_ff @(posedge ck) begin
    if (rs) begin
      ser <= IDLE_BIT;
      sr  <= '0;
      idx <= '0;
    end else if (clear) begin
      ser <= IDLE_BIT;
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      ser <= PATTERN[PAT_W-1];
      sr  <= {PATTERN[PAT_W-2:0], 1'b0};
      idx <= IW'(PAT_W - 1);
    end else if (shift) begin
      ser <= sr[PAT_W-1];
      sr  <= {sr[PAT_W-2:0], 1'b0};
      if (idx != '0) idx <= idx - IW'(1);
    end
  end

  assign last = (idx == '0);

endmodule

// File: rtl/seq0110_tx.sv
// Serial pattern transmitter: first pattern bit one cycle after start, N repetitions with
// GAP idle bits between, then a one-cycle done pulse. No backpressure; abort ends a frame.
module seq0110_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = PATTERN_0110,
  parameter int               CNT_W    = 4,
  parameter int               GAP      = 1,
  parameter logic             IDLE_BIT = IDLE_BIT_DEF
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rep_left
);

  localparam logic [GAP_CNT_W-1:0] GAP_LD = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;
  localparam bit                   NO_GAP = (GAP == 0);

  state_t               state;
  logic [GAP_CNT_W-1:0] gap_cnt;

  logic take, last_rep, kill, rep_end, gap_end, last;
  logic piso_load, piso_shift, piso_clear;

  always_comb begin
    take       = (state == ST_IDLE) && start && (count != '0);
    last_rep   = (rep_left == CNT_W'(1));
    kill       = ((state == ST_SEND) || (state == ST_GAP)) && abort;
    rep_end    = (state == ST_SEND) && !abort && last;
    gap_end    = (state == ST_GAP) && !abort && (gap_cnt == '0);
    piso_load  = take || (rep_end && !last_rep && NO_GAP) || gap_end;
    piso_shift = (state == ST_SEND) && !abort && !last;
    // Blank the line whenever a pattern burst ends without an immediate reload.
    piso_clear = kill || (rep_end && (last_rep || !NO_GAP));
  end

  seq_piso #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .IDLE_BIT(IDLE_BIT)
  ) u_piso (
    .ck   (ck),
    .rs   (rs),
    .load (piso_load),
    .shift(piso_shift),
    .clear(piso_clear),
    .ser  (out),
    .last (last)
  );

  always_ff @(posedge ck) begin
    if (rs) begin
      state    <= ST_IDLE;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rep_left <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (take) begin
            state    <= ST_SEND;
            rep_left <= count;
            valid    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_SEND: begin
          if (abort) begin
            state    <= ST_IDLE;
            valid    <= 1'b0;
            busy     <= 1'b0;
            rep_left <= '0;
          end else if (last) begin
            if (rep_left != '0) rep_left <= rep_left - CNT_W'(1);
            if (last_rep) begin
              state <= ST_DONE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (!NO_GAP) begin
              state   <= ST_GAP;
              valid   <= 1'b0;
              gap_cnt <= GAP_LD;
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            rep_left <= '0;
          end else if (gap_cnt == '0) begin
            state <= ST_SEND;
            valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          valid    <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          rep_left <= '0;
        end
      endcase
    end
  end

endmodule
